// File: rtl/light_sample_sched_pkg.sv
// Shared types and constants for the XADC light-sensor sampling scheduler.
// Contents: FSM state enum, XADC DRP register addresses, ADC resolution.
package light_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StAccum,
    StPublish
  } state_e;

  localparam logic [6:0] XADC_VAUX6 = 7'h16;
  localparam logic [6:0] XADC_TEMP  = 7'h00;

  localparam int unsigned ADC_BITS = 12;

endpackage

// File: rtl/light_sample_sched_if.sv
// DRP bus between the light scheduler (master) and the XADC (slave).
// Signals: den (enable pulse), daddr (register address), drdy (data ready),
// dout (read data).
interface light_sample_sched_if;
  logic        den;
  logic [6:0]  daddr;
  logic        drdy;
  logic [15:0] dout;

  modport master (output den, output daddr, input drdy, input dout);
  modport slave  (input den, input daddr, output drdy, output dout);
endinterface

// File: rtl/light_tick_gen.sv
// Sample-rate divider: emits a one-cycle tick every SAMPLE_DIV cycles while
// enabled, and holds at its reload value while disabled.
// Ports: clk_i, rst_i (async, active high), en_i, tick_o.
module light_tick_gen #(
  parameter int unsigned SAMPLE_DIV = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CntW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CntW-1:0] Reload = CntW'(SAMPLE_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = 1'b0;
    cnt_d  = cnt_q;
    if (!en_i) begin
      cnt_d = Reload;
    end else if (cnt_q == '0) begin
      tick_o = 1'b1;
      cnt_d  = Reload;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= Reload;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/light_sample_sched.sv
// Light-sensor scheduler: periodically reads XADC VAUX6 over DRP, averages
// 2^AVG_LOG2 samples and publishes an 8-bit light level for the MCU port mux.
// Optional threshold interrupt is built when LIGHT_THRESH_IRQ_EN is defined.
// Ports:
//   clk_i, rst_i       - 50 MHz clock, async active-high reset
//   en_i               - sampling enable
//   thresh_i           - interrupt threshold (sampled at publish)
//   intr_ack_i         - one-cycle pulse clearing intr_req_o
//   drp                - DRP master bus (den/daddr out, drdy/dout in)
//   light_o            - published light level
//   light_valid_o      - one-cycle pulse while the new level is published
//   intr_req_o         - level interrupt request
//   busy_o             - FSM not idle
//   timeout_err_o      - sticky: a DRP read got no DRDY in time
//   overrun_o          - sticky: a tick was dropped while busy
module light_sample_sched
  import light_sched_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV  = 50000,
  parameter int unsigned AVG_LOG2    = 3,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter logic [6:0]  DRP_ADDR    = XADC_VAUX6,
  parameter int unsigned HYST        = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic [7:0]                  thresh_i,
  input  logic                        intr_ack_i,
  light_sample_sched_if.master        drp,
  output logic [7:0]                  light_o,
  output logic                        light_valid_o,
  output logic                        intr_req_o,
  output logic                        busy_o,
  output logic                        timeout_err_o,
  output logic                        overrun_o
);

  localparam int unsigned AccW    = ADC_BITS + AVG_LOG2;
  localparam int unsigned CntW    = AVG_LOG2 + 1;
  localparam int unsigned NumSamp = 2 ** AVG_LOG2;
  localparam int unsigned WcW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]  HystL   = 8'(HYST);

  state_e              state_q, state_d;
  logic                pending_q, pending_d;
  logic [AccW-1:0]     acc_q, acc_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ADC_BITS-1:0] samp_q, samp_d;
  logic [WcW-1:0]      wcnt_q, wcnt_d;
  logic [7:0]          light_q, light_d;
  logic                terr_q, terr_d;
  logic                ovr_q, ovr_d;
  logic                tick;
  logic                publish;
  logic [AccW-1:0]     sum;

  light_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick_gen (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (en_i),
    .tick_o(tick)
  );

  assign sum = acc_q + AccW'(samp_q);

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    samp_d        = samp_q;
    wcnt_d        = wcnt_q;
    light_d       = light_q;
    terr_d        = terr_q;
    ovr_d         = ovr_q;
    drp.den       = 1'b0;
    light_valid_o = 1'b0;
    publish       = 1'b0;

    // A tick landing on an unserved request while busy is lost.
    if (tick) begin
      if (pending_q && (state_q != StIdle)) ovr_d = 1'b1;
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (!en_i) begin
          acc_d     = '0;
          cnt_d     = '0;
          pending_d = 1'b0;
        end else if (pending_q) begin
          state_d   = StReq;
          pending_d = tick;
        end
      end
      StReq: begin
        drp.den = 1'b1;
        wcnt_d  = WcW'(1);
        state_d = StWait;
      end
      StWait: begin
        if (drp.drdy) begin
          samp_d  = drp.dout[15:4];
          state_d = StAccum;
        end else if (wcnt_q == WcW'(TIMEOUT_CYC - 1)) begin
          terr_d  = 1'b1;
          state_d = StIdle;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      StAccum: begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(NumSamp - 1)) begin
          // Register the average here so light_o is already new while valid pulses.
          light_d = sum[AVG_LOG2 + ADC_BITS - 1 -: 8];
          state_d = StPublish;
        end else begin
          state_d = StIdle;
        end
      end
      StPublish: begin
        light_valid_o = 1'b1;
        publish       = 1'b1;
        acc_d         = '0;
        cnt_d         = '0;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      samp_q    <= '0;
      wcnt_q    <= '0;
      light_q   <= '0;
      terr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      samp_q    <= samp_d;
      wcnt_q    <= wcnt_d;
      light_q   <= light_d;
      terr_q    <= terr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign drp.daddr     = DRP_ADDR;
  assign light_o       = light_q;
  assign busy_o        = (state_q != StIdle);
  assign timeout_err_o = terr_q;
  assign overrun_o     = ovr_q;

  logic unused_dout_lsb;
  assign unused_dout_lsb = ^drp.dout[3:0];

`ifdef LIGHT_THRESH_IRQ_EN
  logic       armed_q, armed_d;
  logic       intr_q, intr_d;
  logic [7:0] rearm_lvl;

  // Re-arm level saturates at zero, so a tiny threshold never re-arms.
  assign rearm_lvl = (thresh_i > HystL) ? (thresh_i - HystL) : 8'd0;

  always_comb begin
    armed_d = armed_q;
    intr_d  = intr_q;
    if (intr_ack_i) intr_d = 1'b0;
    // light_q already holds the new level during publish; set beats ack.
    if (publish) begin
      if (armed_q && (light_q >= thresh_i)) begin
        intr_d  = 1'b1;
        armed_d = 1'b0;
      end else if (!armed_q && (light_q < rearm_lvl)) begin
        armed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      armed_q <= 1'b1;
      intr_q  <= 1'b0;
    end else begin
      armed_q <= armed_d;
      intr_q  <= intr_d;
    end
  end

  assign intr_req_o = intr_q;
`else
  logic unused_irq;
  assign unused_irq = ^{thresh_i, intr_ack_i, HystL, publish};
  assign intr_req_o = 1'b0;
`endif

endmodule

// File: tb/tb_light_sample_sched.sv
// Directed bench for light_sample_sched with a behavioural DRP responder.
module tb_light_sample_sched;

  localparam int unsigned SampleDiv = 10;
  localparam int unsigned AvgLog2   = 2;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] thresh;
  logic       intr_ack;
  logic [7:0] light;
  logic       light_valid;
  logic       intr_req;
  logic       busy;
  logic       terr;
  logic       ovr;

  light_sample_sched_if drp_if ();

  light_sample_sched #(
    .SAMPLE_DIV (SampleDiv),
    .AVG_LOG2   (AvgLog2),
    .TIMEOUT_CYC(64),
    .DRP_ADDR   (7'h16),
    .HYST       (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .thresh_i     (thresh),
    .intr_ack_i   (intr_ack),
    .drp          (drp_if),
    .light_o      (light),
    .light_valid_o(light_valid),
    .intr_req_o   (intr_req),
    .busy_o       (busy),
    .timeout_err_o(terr),
    .overrun_o    (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder controls (written only by the stimulus block).
  int          rsp_delay = 3;  // 0: never answer
  logic [15:0] samp_mem[128];
  int          wr_idx = 0;
  int unsigned inject_at = 32'hFFFF_FFFF;

  // Responder/monitor state (written only by the responder).
  int          rd_idx = 0;
  int          rsp_cnt = -1;
  int          den_cnt = 0;
  int          den_viol = 0;
  bit          outstanding = 1'b0;
  int unsigned last_den_cyc = 0;
  int unsigned prev_den_cyc = 0;
  int unsigned last_drdy_cyc = 0;

  always @(negedge clk) begin
    drp_if.drdy = 1'b0;
    if (rst) begin
      rsp_cnt     = -1;
      outstanding = 1'b0;
    end else begin
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          drp_if.drdy = 1'b1;
          if (rd_idx != wr_idx) begin
            drp_if.dout = samp_mem[rd_idx % 128];
            rd_idx++;
          end else begin
            drp_if.dout = 16'h0000;
          end
          last_drdy_cyc = cyc;
          outstanding   = 1'b0;
          rsp_cnt       = -1;
        end
      end
      if (!busy) outstanding = 1'b0;
      if (drp_if.den) begin
        den_cnt++;
        if (outstanding) den_viol++;
        outstanding  = 1'b1;
        prev_den_cyc = last_den_cyc;
        last_den_cyc = cyc;
        if (rsp_delay > 0) rsp_cnt = rsp_delay;
      end
    end
    if (cyc == inject_at) drp_if.drdy = 1'b1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] v, input int n);
    repeat (n) begin
      samp_mem[wr_idx % 128] = v;
      wr_idx++;
    end
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int i;
    i = 0;
    while (!light_valid && i < budget) begin
      step(1);
      i++;
    end
    chk(tag, 32'(light_valid), 32'd1);
  endtask

  task automatic wait_den(input int budget, input string tag);
    int i;
    int base;
    i    = 0;
    base = den_cnt;
    while (den_cnt == base && i < budget) begin
      step(1);
      i++;
    end
    chk(tag, 32'(den_cnt != base), 32'd1);
  endtask

  int          den0;
  int unsigned r0;
  int unsigned diff;
  logic [7:0]  lvls[6];
  logic        exp_irq[6];

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    thresh   = 8'h80;
    intr_ack = 1'b0;
    step(3);

    // Reset state
    chk("rst_light", 32'(light), 32'h0);
    chk("rst_valid", 32'(light_valid), 32'h0);
    chk("rst_intr", 32'(intr_req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_terr", 32'(terr), 32'h0);
    chk("rst_ovr", 32'(ovr), 32'h0);
    chk("rst_den", 32'(drp_if.den), 32'h0);
    chk("rst_daddr", 32'(drp_if.daddr), 32'h16);

    // 1: four mid-scale samples
    push(16'h8000, 4);
    rst  = 1'b0;
    en   = 1'b1;
    den0 = den_cnt;
    wait_valid(200, "t1_valid");
    chk("t1_light", 32'(light), 32'h80);
    chk("t1_den_count", 32'(den_cnt - den0), 32'd4);
    chk("t1_den_period", last_den_cyc - prev_den_cyc, 32'd10);
    chk("t1_drdy_to_valid", cyc - last_drdy_cyc, 32'd2);
    chk("t1_daddr", 32'(drp_if.daddr), 32'h16);
    push(16'h0000, 1);
    push(16'hFFF0, 1);
    push(16'h0000, 1);
    push(16'hFFF0, 1);
    step(1);
    chk("t1_valid_pulse", 32'(light_valid), 32'h0);
    chk("t1_light_hold", 32'(light), 32'h80);
    chk("t1_ovr", 32'(ovr), 32'h0);

    // 2: alternating extremes average to 0x7FF
    den0 = den_cnt;
    wait_valid(200, "t2_valid");
    chk("t2_light", 32'(light), 32'h7F);
    chk("t2_den_count", 32'(den_cnt - den0), 32'd4);
    chk("t2_den_period", last_den_cyc - prev_den_cyc, 32'd10);
    chk("t2_terr", 32'(terr), 32'h0);

    // 3: DRDY never arrives
    rsp_delay = 0;
    push(16'h4000, 4);
    wait_den(40, "t3_den");
    step(63);
    chk("t3_busy_before", 32'(busy), 32'h1);
    chk("t3_terr_before", 32'(terr), 32'h0);
    step(1);
    chk("t3_idle_at_64", 32'(busy), 32'h0);
    chk("t3_terr_set", 32'(terr), 32'h1);
    rsp_delay = 3;
    den0      = den_cnt;
    wait_valid(300, "t3_valid");
    chk("t3_light", 32'(light), 32'h40);
    chk("t3_den_count", 32'(den_cnt - den0), 32'd4);
    chk("t3_terr_sticky", 32'(terr), 32'h1);

    // 4: slow DRDY forces overrun
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk("t4_rst_ovr", 32'(ovr), 32'h0);
    chk("t4_rst_terr", 32'(terr), 32'h0);
    rsp_delay = 25;
    push(16'hC000, 4);
    den0 = den_cnt;
    wait_valid(400, "t4_valid");
    chk("t4_light", 32'(light), 32'hC0);
    chk("t4_ovr", 32'(ovr), 32'h1);
    chk("t4_den_count", 32'(den_cnt - den0), 32'd4);
    chk("t4_den_viol", 32'(den_viol), 32'd0);

    // 6: reset while waiting, then a late DRDY
    wait_den(40, "t6_den");
    step(3);
    chk("t6_in_wait", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_light", 32'(light), 32'h0);
    chk("t6_ovr", 32'(ovr), 32'h0);
    chk("t6_den", 32'(drp_if.den), 32'h0);
    inject_at = cyc + 2;
    rsp_delay = 3;
    step(1);
    rst = 1'b0;
    r0  = cyc;
    step(2);
    chk("t6_late_drdy_ignored", 32'(busy), 32'h0);
    step(1);
    chk("t6_late_drdy_idle", 32'(busy), 32'h0);
    wait_den(30, "t6_next_den");
    diff = cyc - r0;
    chk("t6_den_delay", 32'(diff >= SampleDiv && diff <= SampleDiv + 2), 32'd1);

    // EN low: finish the read, then stay idle with no further DEN
    en = 1'b0;
    step(12);
    den0 = den_cnt;
    step(30);
    chk("en_off_idle", 32'(busy), 32'h0);
    chk("en_off_no_den", 32'(den_cnt - den0), 32'd0);
    chk("en_off_light_hold", 32'(light), 32'h0);

`ifdef LIGHT_THRESH_IRQ_EN
    // 5: threshold interrupt with hysteresis
    lvls    = '{8'h70, 8'h90, 8'hA0, 8'h7C, 8'h77, 8'h90};
    exp_irq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 6; k++) push({lvls[k], 8'h00}, 4);
    thresh = 8'h80;
    en     = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_valid(200, "t5_valid");
      chk("t5_light", 32'(light), 32'(lvls[k]));
      if (k == 5) intr_ack = 1'b1;
      step(1);
      intr_ack = 1'b0;
      chk("t5_intr", 32'(intr_req), 32'(exp_irq[k]));
      if (k == 1) begin
        intr_ack = 1'b1;
        step(1);
        intr_ack = 1'b0;
        chk("t5_ack_clears", 32'(intr_req), 32'h0);
      end
    end
`else
    push(16'h9000, 4);
    thresh = 8'h80;
    en     = 1'b1;
    wait_valid(200, "t5_valid");
    chk("t5_light", 32'(light), 32'h90);
    step(1);
    chk("t5_intr_off", 32'(intr_req), 32'h0);
    intr_ack = 1'b1;
    step(1);
    intr_ack = 1'b0;
    chk("t5_intr_off_ack", 32'(intr_req), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/light_sample_sched.md
Name: light_sample_sched

Overview:
Scheduler/controller for the XADC light-sensor datapath feeding the RAT MCU LIGHT input port.
- Periodically issues DRP reads of the VAUX6 channel and averages 2^AVG_LOG2 samples.
- Publishes an 8-bit light level for the MCU port mux.
- Optionally raises a threshold-crossing interrupt request toward the MCU INTR line.
- Runs in the 50 MHz MCU clock domain.

Parameters:
- SAMPLE_DIV, 50000: clock cycles between sample ticks (1 ms at 50 MHz); legal range >= 2.
- AVG_LOG2, 3: log2 of the number of samples averaged per published value; legal range 0..6.
- TIMEOUT_CYC, 64: maximum cycles to wait for DRDY before aborting a read.
- DRP_ADDR, 7'h16: XADC status register address of VAUX6.
- HYST, 8: re-arm hysteresis in light units.

Ports:
- CLK, in, 1: 50 MHz clock.
- RESET, in, 1: asynchronous, active-high reset.
- EN, in, 1: enables sampling.
- THRESH, in, 8: interrupt threshold.
- INTR_ACK, in, 1: single-cycle pulse that clears INTR_REQ.
- DRP_DEN, out, 1: DRP enable pulse.
- DRP_DADDR, out, 7: DRP address.
- DRP_DRDY, in, 1: DRP data ready.
- DRP_DO, in, 16: DRP read data.
- LIGHT, out, 8: published light level.
- LIGHT_VALID, out, 1: single-cycle pulse when LIGHT updates.
- INTR_REQ, out, 1: level interrupt request.
- BUSY, out, 1: high in any state other than IDLE.
- TIMEOUT_ERR, out, 1: sticky error flag.
- OVERRUN, out, 1: sticky error flag.

Behaviour:
- Reset values: all outputs 0, DRP_DADDR = DRP_ADDR, FSM in IDLE, tick counter = SAMPLE_DIV-1, accumulator 0, sample count 0, pending 0, armed 1.
- Tick counter: decrements every cycle while EN=1. At 0 it emits a one-cycle tick and reloads SAMPLE_DIV-1. While EN=0 it holds at SAMPLE_DIV-1.
- Pending flag: a tick sets it. If a tick arrives while pending is already 1 and the FSM is not IDLE, OVERRUN sets (sticky) and the tick is dropped.
- FSM states: IDLE, REQ, WAIT, ACCUM, PUBLISH.
  - IDLE -> REQ when pending=1 and EN=1; pending clears.
  - REQ: DRP_DEN=1 for exactly one cycle -> WAIT.
  - WAIT -> ACCUM on the cycle DRP_DRDY=1; DRP_DO[15:4] is captured.
  - WAIT -> IDLE after TIMEOUT_CYC cycles without DRDY. TIMEOUT_ERR sets; the sample is discarded; count is unchanged.
  - ACCUM: acc += captured 12-bit value (acc width 12+AVG_LOG2, no overflow possible); count++. If count reaches 2^AVG_LOG2 -> PUBLISH, else -> IDLE.
  - PUBLISH: avg = acc >> AVG_LOG2; LIGHT <= avg[11:4]; LIGHT_VALID=1 for one cycle; acc and count clear -> IDLE.
- Latency: tick to DEN is 2 cycles. DRDY to LIGHT_VALID for the final sample is 2 cycles.
- EN deasserted mid-operation: the in-flight DRP transaction completes (DEN is never re-issued). Once in IDLE, acc, count and pending clear. LIGHT holds its last value.
- DRDY while not in WAIT: ignored.
- RESET mid-transaction: immediate return to reset values. A late DRDY is ignored.
- Sticky flags clear only on RESET.

Optional Feature:
Macro LIGHT_THRESH_IRQ_EN.
- Defined:
  - On each PUBLISH, if armed and LIGHT_new >= THRESH: INTR_REQ sets and armed clears.
  - If not armed and LIGHT_new < THRESH-HYST (saturating at 0): armed sets.
  - INTR_REQ holds until INTR_ACK. If set and ACK occur in the same cycle, set wins.
  - THRESH is sampled at PUBLISH.
- Undefined: INTR_REQ tied 0, INTR_ACK ignored, no armed register.

Decomposition:
- Package light_sched_pkg: FSM state enum (IDLE, REQ, WAIT, ACCUM, PUBLISH), XADC address constants (VAUX6 = 7'h16, TEMP = 7'h00), ADC_BITS = 12.
- One natural sub-module, light_tick_gen: the SAMPLE_DIV divider with EN and reload.
- FSM, accumulator and interrupt logic stay in the top.

Test Plan:
1. SAMPLE_DIV=10, AVG_LOG2=2, DRP model returns DO = 16'h8000 with DRDY 3 cycles after DEN. Required: DEN every 10 cycles, DRP_DADDR = 7'h16, after the 4th sample LIGHT = 8'h80 with a one-cycle LIGHT_VALID.
2. Samples DO = 16'h0000, 16'hFFF0, 16'h0000, 16'hFFF0 (AVG_LOG2=2). Required: avg = 12'h7FF and LIGHT = 8'h7F.
3. DRP model never asserts DRDY, TIMEOUT_CYC=64. Required: FSM returns to IDLE 64 cycles after DEN, TIMEOUT_ERR=1 and stays 1, count unchanged. A subsequent good run still publishes correctly.
4. DRDY delay of 25 cycles with SAMPLE_DIV=10. Required: OVERRUN=1, exactly one DEN per completed transaction, never two DEN without an intervening DRDY or timeout.
5. LIGHT_THRESH_IRQ_EN defined, THRESH=8'h80, HYST=8, published sequence 8'h70, 8'h90, 8'hA0, 8'h7C, 8'h77, 8'h90. Required: INTR_REQ rises after 8'h90 only, cleared by INTR_ACK; no re-fire at 8'hA0 or 8'h7C; re-arm at 8'h77; fires again at the final 8'h90.
6. Assert RESET while in WAIT, then DRDY pulses 2 cycles later. Required: all outputs return to reset values immediately, the late DRDY is ignored, and the next DEN occurs SAMPLE_DIV cycles after RESET deasserts.
